// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_EMPTY     = 2;
  localparam int unsigned STAT_OVF       = 3;
  localparam int unsigned STAT_COUNT_LSB = 4;

  localparam logic [15:0] MIN_DIVISOR = 16'd2;

  function automatic logic [15:0] clamp_divisor(input logic [15:0] d);
    return (d < MIN_DIVISOR) ? MIN_DIVISOR : d;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// Synchronous FIFO with combinational head read; a push into a full FIFO succeeds only alongside a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  assign w_do_push = push && ((r_count != FULL_COUNT) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_do_pop && !w_do_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_count == FULL_COUNT);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/mmio_uart_tx.sv
// UART 8N1 transmitter decoding a 16-byte MMIO window on the CPU bus; BRAM-style registered reads.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS    = 32'h0000_0200,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  input  logic        memWrite,
  input  logic [3:0]  byteMask,
  output logic [31:0] memReadData,
  output logic        tx
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_hit, w_wr, w_push_req, w_pop, w_bit_end;
  logic [1:0]    w_offset;
  logic [7:0]    w_fifo_rdata, w_status;
  logic          w_full, w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_count_wide;
  logic [3:0]    w_count_sat;
  logic [15:0]   w_div_merged;
  logic          w_unused_bits;

  uart_state_t   r_state;
  logic          r_tx, r_overflow;
  logic [15:0]   r_divisor, r_frame_div, r_bit_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [31:0]   r_rdata;

  assign w_hit      = (memAddress[31:4] == BASE_ADDRESS[31:4]);
  assign w_offset   = memAddress[3:2];
  assign w_wr       = w_hit && memWrite;
  assign w_push_req = w_wr && (w_offset == REG_DATA) && byteMask[0];
  assign w_bit_end  = (r_bit_cnt == r_frame_div - 16'd1);
  // Pop either from idle or on the last stop-bit cycle so frames chain with no gap.
  assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));
  assign w_unused_bits = ^{memWriteData[31:16], memAddress[1:0], byteMask[3:2]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push_req),
    .pop   (w_pop),
    .wdata (memWriteData[7:0]),
    .rdata (w_fifo_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_count_wide = 32'(w_count);
  assign w_count_sat  = (w_count_wide > 32'd15) ? 4'hF : w_count_wide[3:0];

  always_comb begin
    w_status = '0;
    w_status[STAT_BUSY]  = (r_state != IDLE);
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_OVF]   = r_overflow;
    w_status[STAT_COUNT_LSB +: 4] = w_count_sat;
  end

  assign w_div_merged = {byteMask[1] ? memWriteData[15:8] : r_divisor[15:8],
                         byteMask[0] ? memWriteData[7:0]  : r_divisor[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_divisor  <= clamp_divisor(DEFAULT_DIVISOR);
      r_rdata    <= '0;
    end else begin
      if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
      else if (w_wr && (w_offset == REG_STATUS) && byteMask[0] && memWriteData[STAT_OVF])
        r_overflow <= 1'b0;
      if (w_wr && (w_offset == REG_DIVISOR) && (byteMask[1:0] != 2'b00))
        r_divisor <= clamp_divisor(w_div_merged);
      r_rdata <= '0;
      if (w_hit) begin
        case (w_offset)
          REG_STATUS:  r_rdata <= {24'b0, w_status};
          REG_DIVISOR: r_rdata <= {16'b0, r_divisor};
          default:     r_rdata <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_tx        <= 1'b1;
      r_bit_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_frame_div <= clamp_divisor(DEFAULT_DIVISOR);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift     <= w_fifo_rdata;
            r_frame_div <= r_divisor;
            r_bit_cnt   <= '0;
            r_tx        <= 1'b0;
            r_state     <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else r_bit_cnt <= r_bit_cnt + 16'd1;
        end
        DATA: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else r_bit_cnt <= r_bit_cnt + 16'd1;
        end
        STOP: begin
          if (w_bit_end) begin
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift     <= w_fifo_rdata;
              r_frame_div <= r_divisor;
              r_tx        <= 1'b0;
              r_state     <= START;
            end else r_state <= IDLE;
          end else r_bit_cnt <= r_bit_cnt + 16'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx          = r_tx;
  assign memReadData = r_rdata;

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the CPU data bus, in parallel with BRAM_MMIO. It consumes the same memAddress/memWriteData/byteMask/memWrite signals the CPU drives and decodes its own 16-byte window. Bytes written to DATA are queued in a FIFO and serialized as 8N1 frames on tx. STATUS and DIVISOR are readable with BRAM-style 1-cycle read latency.

Parameters:
BASE_ADDRESS, 32'h0000_0200, base of the 16-byte register window (must be 16-byte aligned).
FIFO_DEPTH, 8, transmit FIFO entries (power of two, at least 2).
DEFAULT_DIVISOR, 16'd868, clock cycles per bit after reset.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
memAddress  in  32  byte address from CPU
memWriteData  in  32  write data from CPU
memWrite  in  1  write strobe, sampled on rising clk
byteMask  in  4  byte-lane enables for writes
memReadData  out  32  registered read data
tx  out  1  serial output, idles high

Behaviour:
- Decode: hit = (memAddress[31:4] == BASE_ADDRESS[31:4]); offset = memAddress[3:2]. 0 = DATA, 1 = STATUS, 2 = DIVISOR, 3 = reserved.
- Reset (reset=0, async): tx=1, memReadData=0, FIFO empty, overflow=0, divisor=DEFAULT_DIVISOR, FSM=IDLE.
- Read: every edge, memReadData <= selected register if hit, else 0.
  - DATA and reserved read 0.
  - STATUS = {24'b0, count[3:0], overflow, empty, full, busy}: bit0 busy (FSM != IDLE), bit1 full, bit2 empty, bit3 overflow, bits[7:4] FIFO count (saturates at 15).
  - DIVISOR = {16'b0, divisor}.
- Write DATA: hit, memWrite=1, byteMask[0]=1 -> push memWriteData[7:0].
  - FIFO full -> byte dropped and overflow set (sticky).
  - Push and pop on the same edge while full -> both happen; count unchanged; no overflow.
- Write STATUS: byteMask[0]=1 and memWriteData[3]=1 clears overflow. Other bits are ignored.
- Write DIVISOR: the lanes enabled in byteMask[1:0] update divisor[15:0]. A resulting value below 2 is stored as 2.
- FSM states: IDLE, START, DATA, STOP. The bit counter counts 0..divisor-1 within each bit.
  - IDLE: if FIFO is non-empty, pop, latch the byte and the current divisor, go to START.
  - START: tx=0 for divisor cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for divisor cycles, then go to STOP.
  - STOP: tx=1 for divisor cycles. Then pop and go to START if FIFO is non-empty, else go to IDLE. There is no idle gap between frames.
- tx is registered. Write sampled at edge E0 -> FIFO non-empty after E0 -> pop at E1 -> tx=0 after E1.
- A frame is exactly 10*divisor cycles.
- A DIVISOR write mid-frame takes effect at the next frame start.
- Reset asserted mid-frame aborts immediately: tx=1, queued bytes are lost.

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Register offset constants (DATA=0, STATUS=1, DIVISOR=2).
  - STATUS bit-position constants.
  - MIN_DIVISOR=2.
- Sub-module sync_fifo: parameters WIDTH=8, DEPTH.
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Same clock and reset as the parent.
  - rdata is combinational from the head entry.
- The top level holds the address decode, registers, baud counter and FSM.

Test Plan:
1. Reset for 2 cycles, then release. Read STATUS (0x204) -> 0x00000004 one cycle later; DIVISOR (0x208) -> 0x00000364; tx=1.
2. Write DIVISOR=4, then DATA=0x000000A5 with byteMask=4'b0001. tx goes low on the second edge after the write. Sequence: 0 x4, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1 x4; 40 cycles total. STATUS bit0=1 during the frame, 0 after.
3. With DIVISOR=4, write 0x11 and 0x22 back-to-back. The second start bit begins on the cycle after the first stop bit ends (frames are 40 cycles apart). Both bytes are decoded correctly.
4. With DIVISOR=100, write 10 bytes in consecutive cycles. The first pops immediately, 8 fill the FIFO, the 10th is dropped. STATUS reads full=1, overflow=1, count=8. Write STATUS 0x8 -> overflow=0. Exactly 9 frames are emitted.
5. Write DIVISOR=1 -> reads back 2. Write DATA with byteMask=4'b0010 -> no push; STATUS empty stays 1. Writes to address 0x210 do not affect the block, and reads of 0x210 return 0.
6. Assert reset mid-frame (during DATA bit 3). tx=1 immediately, with no waiting for a clock edge. After release, STATUS=0x4 and DIVISOR=0x364.
